// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared types and constants for the mandelbrot counter sink
package mandel_pkg;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

  localparam int CTRW_OUT = 4;
  localparam int BYTE_W   = 8;
  localparam logic [CTRW_OUT-1:0] PAD_NIBBLE = 4'h0;

endpackage

// File: rtl/mandel_sync_fifo.sv
// rtl/mandel_sync_fifo.sv - synchronous FIFO with a head output and a retro-mark of the newest entry
module mandel_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             mark_last,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, newest_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full       = (cnt == FULL_CNT);
  assign empty      = (cnt == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign newest_ptr = wr_ptr - AW'(1);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end else if (mark_last && !empty) begin
        // The top bit of an entry is its end-of-frame flag.
        mem[newest_ptr][WIDTH-1] <= 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mandel_ctr_sink.sv
// rtl/mandel_ctr_sink.sv - captures generator nibbles, packs bytes, queues them for the serializer
module mandel_ctr_sink
  import mandel_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              gen_run,
  input  logic              gen_running,
  input  logic [CTRW_OUT-1:0] ctr_out,
  input  logic              new_ctr,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              busy,
  output logic              overflow,
  output logic              short_frame
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       pix_cnt;
  logic [CTRW_OUT-1:0] hold;
  logic                hold_valid;
  logic                capture, frame_done, early_stop, ends_frame;
  logic                push, mark_last, pop, push_ok, full, empty;
  logic [BYTE_W:0]     push_data, head;

  assign capture    = new_ctr && (state == ARM || state == CAPTURE);
  assign frame_done = capture && (pix_cnt == LAST_IDX);
  assign early_stop = (state == CAPTURE) && !gen_running && !frame_done;
  assign ends_frame = frame_done || early_stop;
  assign pop        = !empty && byte_ready;
  assign push_ok    = !full || pop;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    mark_last = 1'b0;
    // A nibble arriving on the stop cycle is packed before the frame is closed.
    if (capture) begin
      if (pix_cnt[0]) begin
        push      = 1'b1;
        push_data = {ends_frame, ctr_out, hold};
      end else if (ends_frame) begin
        push      = 1'b1;
        push_data = {1'b1, PAD_NIBBLE, ctr_out};
      end
    end else if (early_stop) begin
      if (hold_valid) begin
        push      = 1'b1;
        push_data = {1'b1, PAD_NIBBLE, hold};
      end else begin
        mark_last = 1'b1;
      end
    end
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (frame_done) state_nxt = DRAIN;
               else if (gen_running) state_nxt = CAPTURE;
      CAPTURE: if (ends_frame) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_run     <= 1'b0;
      pix_cnt     <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else if (state == IDLE && start) begin
      gen_run     <= 1'b1;
      pix_cnt     <= '0;
      hold_valid  <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (state == ARM && (gen_running || frame_done)) gen_run <= 1'b0;
      if (capture) begin
        pix_cnt <= pix_cnt + CW'(1);
        if (!pix_cnt[0] && !ends_frame) begin
          hold       <= ctr_out;
          hold_valid <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
        end
      end else if (early_stop) begin
        hold_valid <= 1'b0;
      end
      // The counter still advances on a dropped byte so frame geometry holds.
      if (push && !push_ok) overflow <= 1'b1;
      if (early_stop) short_frame <= 1'b1;
    end
  end

  mandel_sync_fifo #(
    .WIDTH(BYTE_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .mark_last (mark_last),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign byte_data  = head[BYTE_W-1:0];
  assign byte_valid = !empty;
  assign byte_last  = head[BYTE_W] && !empty;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mandel_ctr_sink.sv
// tb/tb_mandel_ctr_sink.sv - table-driven and sequence checks for mandel_ctr_sink
module tb_mandel_ctr_sink;

  logic       clk = 1'b0;
  logic       rst_n, start, start_odd, gen_running, new_ctr, byte_ready;
  logic [3:0] ctr_out;
  logic       gen_run, busy, byte_valid, byte_last, overflow, short_frame;
  logic [7:0] byte_data;
  logic       o_gen_run, o_busy, o_valid, o_last, o_overflow, o_short;
  logic [7:0] o_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mandel_ctr_sink #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gen_run(gen_run), .gen_running(gen_running),
    .ctr_out(ctr_out), .new_ctr(new_ctr), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .busy(busy), .overflow(overflow),
    .short_frame(short_frame)
  );

  mandel_ctr_sink #(.IMG_W(3), .IMG_H(1), .FIFO_DEPTH(4)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start_odd), .gen_run(o_gen_run), .gen_running(gen_running),
    .ctr_out(ctr_out), .new_ctr(new_ctr), .byte_data(o_data), .byte_valid(o_valid),
    .byte_last(o_last), .byte_ready(byte_ready), .busy(o_busy), .overflow(o_overflow),
    .short_frame(o_short)
  );

  typedef struct {
    logic       st, run, nv;
    logic [3:0] nib;
    logic       rdy;
    logic       gr, bsy, vld;
    logic [7:0] dat;
    logic       lst, ovf, sht;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, run, nv, input logic [3:0] nib, input logic rdy,
                              input logic gr, bsy, vld, input logic [7:0] dat,
                              input logic lst, ovf, sht);
    vec_t v;
    v.st = st; v.run = run; v.nv = nv; v.nib = nib; v.rdy = rdy;
    v.gr = gr; v.bsy = bsy; v.vld = vld; v.dat = dat; v.lst = lst; v.ovf = ovf; v.sht = sht;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] got_data[$];
  logic       got_last[$];

  initial begin
    // Fields: start run new_ctr nib ready | gen_run busy valid data last overflow short
    // Nominal 4x2 frame, nibbles 1..8, ready held high
    tbl.push_back(mk(1,0,0,4'h0,1, 1,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 1,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,4'h0,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h1,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h2,1, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h3,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h4,1, 0,1,1,8'h43,0,0,0));
    tbl.push_back(mk(0,1,1,4'h5,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h6,1, 0,1,1,8'h65,0,0,0));
    tbl.push_back(mk(0,1,1,4'h7,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h8,1, 0,1,1,8'h87,1,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,0,0,8'h00,0,0,0));
    // Backpressure into a 2-deep FIFO: 0x65 and 0x87 are dropped
    tbl.push_back(mk(1,0,0,4'h0,0, 1,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,4'h0,0, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h1,0, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h2,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h3,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h4,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h5,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h6,0, 0,1,1,8'h21,0,1,0));
    tbl.push_back(mk(0,1,1,4'h7,0, 0,1,1,8'h21,0,1,0));
    tbl.push_back(mk(0,1,1,4'h8,0, 0,1,1,8'h21,0,1,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,1,8'h43,0,1,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,0,8'h00,0,1,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,0,0,8'h00,0,1,0));
    // Early stop after pixels 5,6,7
    tbl.push_back(mk(1,0,0,4'h0,1, 1,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,4'h0,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h5,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h6,1, 0,1,1,8'h65,0,0,0));
    tbl.push_back(mk(0,1,1,4'h7,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,1,8'h07,1,0,1));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,0,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,0,0,8'h00,0,0,1));
    // Fill the FIFO, then push and pop on the same edge while full; start mid-frame is ignored
    tbl.push_back(mk(1,0,0,4'h0,0, 1,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,0,4'h0,0, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h1,0, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,4'h2,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(1,1,1,4'h3,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h4,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h5,0, 0,1,1,8'h21,0,0,0));
    tbl.push_back(mk(0,1,1,4'h6,1, 0,1,1,8'h43,0,0,0));
    tbl.push_back(mk(0,1,1,4'h7,1, 0,1,1,8'h65,0,0,0));
    tbl.push_back(mk(0,1,1,4'h8,1, 0,1,1,8'h87,1,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,1,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,4'h0,1, 0,0,0,8'h00,0,0,0));

    rst_n = 1'b0; start = 1'b0; start_odd = 1'b0; gen_running = 1'b0;
    new_ctr = 1'b0; ctr_out = 4'h0; byte_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gen_run, busy, byte_valid, byte_last, overflow, short_frame, byte_data},
        32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st; gen_running = tbl[i].run; new_ctr = tbl[i].nv;
      ctr_out = tbl[i].nib; byte_ready = tbl[i].rdy;
      tick();
      chk($sformatf("row%0d_ctl", i), {gen_run, busy, byte_valid, overflow, short_frame},
          {tbl[i].gr, tbl[i].bsy, tbl[i].vld, tbl[i].ovf, tbl[i].sht});
      if (tbl[i].vld)
        chk($sformatf("row%0d_byte", i), {byte_last, byte_data}, {tbl[i].lst, tbl[i].dat});
    end

    // Odd-length 3x1 frame on the second instance
    start = 1'b0; byte_ready = 1'b1; gen_running = 1'b0; new_ctr = 1'b0;
    start_odd = 1'b1; tick();
    chk("odd_arm_gen_run", o_gen_run, 1);
    start_odd = 1'b0; gen_running = 1'b1; tick();
    new_ctr = 1'b1; ctr_out = 4'hA; tick();
    ctr_out = 4'hB; tick();
    chk("odd_byte0", {o_valid, o_last, o_data}, {1'b1, 1'b0, 8'hBA});
    ctr_out = 4'hC; tick();
    chk("odd_byte1", {o_valid, o_last, o_data}, {1'b1, 1'b1, 8'h0C});
    new_ctr = 1'b0; gen_running = 1'b0; tick();
    chk("odd_drained", {o_valid, o_busy}, 2'b01);
    tick();
    chk("odd_idle", {o_busy, o_overflow, o_short}, 3'b000);
    chk("main_ignored_odd_stream", {busy, byte_valid}, 2'b00);

    // Reset while two bytes are queued and a third was dropped
    start = 1'b1; tick();
    start = 1'b0; gen_running = 1'b1; tick();
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      new_ctr = 1'b1; ctr_out = 4'(i + 1); tick();
    end
    new_ctr = 1'b0;
    chk("pre_reset_state", {byte_valid, overflow, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {gen_run, busy, byte_valid, byte_last, overflow, short_frame, byte_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame after reset, collecting bytes as they pass
    byte_ready = 1'b1;
    start = 1'b1; tick();
    start = 1'b0; tick();
    for (int c = 0; c < 40; c++) begin
      new_ctr = (c < 8); ctr_out = 4'(c + 1);
      tick();
      if (byte_valid) begin
        got_data.push_back(byte_data);
        got_last.push_back(byte_last);
      end
      if (!busy) break;
    end
    new_ctr = 1'b0;
    chk("restart_done", busy, 0);
    chk("restart_byte_count", got_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_data.size()) begin
        chk($sformatf("restart_byte%0d", k), {got_last[k], got_data[k]},
            {(k == 3), 4'(2 * k + 2), 4'(2 * k + 1)});
      end
    end
    chk("restart_flags", {overflow, short_frame}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mandel_ctr_sink.md
Name: mandel_ctr_sink

Overview:
- Receiving end of the mandelbrot counter stream. Starts a frame on the generator by driving its run input, then captures each ctr_out nibble that arrives with a new_ctr strobe.
- Packs nibble pairs into bytes and buffers them in a small FIFO.
- Delivers the bytes over a valid/ready byte interface to the downstream output serializer, and flags the final byte of each frame.

Parameters:
- IMG_W, 8, pixels per line.
- IMG_H, 4, lines per frame; frame length NPIX = IMG_W*IMG_H.
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to acquire one frame.
- gen_run  out  1  drives the generator's run input.
- gen_running  in  1  generator's running output.
- ctr_out  in  4  counter nibble from the generator.
- new_ctr  in  1  qualifies ctr_out, one cycle per pixel.
- byte_data  out  8  packed pixel pair; the first pixel is in [3:0].
- byte_valid  out  1  FIFO non-empty.
- byte_last  out  1  valid with byte_data; marks the final byte of the frame.
- byte_ready  in  1  downstream accepts when valid && ready.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- short_frame  out  1  sticky: running fell before NPIX pixels were received.

Behaviour:
- Reset values: gen_run=0, byte_valid=0, byte_data=0, byte_last=0, busy=0, overflow=0, short_frame=0. FIFO is empty, pixel counter is 0, nibble holding register is empty, FSM is in IDLE. Reset mid-frame discards all state immediately.
- IDLE:
  - start=1 -> ARM.
  - On the same edge: clear overflow and short_frame, pixel counter := 0, set gen_run=1.
  - start is ignored in every other state.
- ARM:
  - gen_run stays 1 until gen_running=1 is sampled; then gen_run := 0 and go to CAPTURE.
  - A new_ctr seen in ARM is captured exactly as in CAPTURE.
- CAPTURE, on each new_ctr=1:
  - Even pixel index: store ctr_out in the hold register.
  - Odd pixel index: form byte {ctr_out, hold} and push it.
  - Pixel counter increments.
- Frame completion:
  - On the NPIX-th pixel, the pushed byte carries last=1. If NPIX is odd, the final byte is {4'h0, hold}, also with last=1.
  - FSM goes to DRAIN on the edge that pushes the last byte.
- Early stop:
  - gen_running=0 in CAPTURE with count < NPIX: set short_frame.
  - If a nibble is held, push {4'h0, hold} with last=1; if none is held, mark the most recent FIFO entry last=1 (if the FIFO is empty, nothing).
  - Go to DRAIN.
  - new_ctr on that same cycle is captured first.
- DRAIN: stay until the FIFO is empty, then go to IDLE. busy=0 starts the following cycle.
- Any new_ctr in DRAIN or IDLE is ignored.
- FIFO:
  - Pop when byte_valid && byte_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the byte is dropped and overflow := 1. The pixel counter still advances, so frame geometry is preserved.
  - Push into an empty FIFO: byte_valid=1 on the next cycle, so latency is 1 cycle from the odd new_ctr.
  - Pointers wrap at FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Ordering: byte_data, byte_valid and byte_last are registered FIFO-head outputs. Each stores a 9-bit entry {last, data}.
- Pixel counter width is clog2(NPIX+1) and never exceeds NPIX.

Decomposition:
- Shared package mandel_pkg:
  - FSM state enum: IDLE, ARM, CAPTURE, DRAIN.
  - CTRW_OUT=4, BYTE_W=8.
  - Pad-nibble constant 4'h0.
- One sub-module: mandel_sync_fifo, parameterised WIDTH=9 and DEPTH, with push/pop/full/empty and a head output.
- Packing, counting and the FSM stay in the top module.

Test Plan:
- Nominal frame, IMG_W=4, IMG_H=2:
  - Stimulus: start, generator raises running, 8 new_ctr with nibbles 1..8, byte_ready=1.
  - Required: gen_run high until running is sampled; bytes 0x21, 0x43, 0x65, 0x87 in order, byte_last only on 0x87; busy low after drain; no flags.
- Odd frame, IMG_W=3, IMG_H=1:
  - Stimulus: nibbles A, B, C.
  - Required: bytes 0xBA, then 0x0C with last=1.
- Backpressure, FIFO_DEPTH=2, byte_ready=0:
  - Stimulus: 8 pixels.
  - Required: two bytes kept (0x21, 0x43), overflow=1 after the third push; releasing ready yields exactly those two bytes, the second without last.
- Early stop:
  - Stimulus: running drops after 3 pixels (5, 6, 7).
  - Required: bytes 0x65, then 0x07 with last=1; short_frame=1; returns to IDLE.
- Full FIFO with simultaneous push and pop, byte_ready=1:
  - Required: no overflow, bytes continuous.
- Reset and restart:
  - Stimulus: assert rst_n low mid-CAPTURE with 2 bytes queued.
  - Required: all outputs return to reset values asynchronously; a following start gives a clean frame.
  - Also: start pulsed while busy is ignored.
